timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 94 +++++++++
 tb/tb_timer_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: microwave-style cook timer controller (optional completion beep via DONE_BEEP_EN)
module timer_ctrl #(
    parameter int TICK_DIV    = 100,
    parameter int BEEP_CYCLES = 300
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        start,
    input  logic        stop,
    input  logic        door_closed,
    input  logic        timer_zero,
    output logic [11:0] timer_data,
    output logic        timer_load,
    output logic        timer_enable,
    output logic        timer_clearn,
    output logic        mag_on,
    output logic [2:0]  state,
    output logic        beep
);
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, COOK = 3'd2, PAUSE = 3'd3, DONE = 3'd4} state_t;
    localparam logic [15:0] PMAX = 16'(TICK_DIV - 1);
    state_t cur, nxt;
    logic [11:0] entry, entry_nxt;
    logic [15:0] pre, pre_nxt;
    logic tick, done_exit;
    logic halt;
    assign halt = stop || !door_closed;
`ifdef DONE_BEEP_EN
    localparam int BW = BEEP_CYCLES > 1 ? $clog2(BEEP_CYCLES) : 1;
    logic [BW-1:0] bcnt;
    assign done_exit = bcnt == BW'(BEEP_CYCLES - 1) || stop || start || key_valid;
    assign beep = cur == DONE;
    // beep duration counter, restarts every time DONE is entered
    always_ff @(posedge clk)
        if (clear || cur != DONE) bcnt <= '0;
        else bcnt <= bcnt + 1'b1;
`else
    assign done_exit = 1'b1;
    assign beep = BEEP_CYCLES < 0;
`endif
    // next-state, entry shifting and prescaler stepping
    always_comb begin
        nxt = cur;
        entry_nxt = entry;
        pre_nxt = pre;
        tick = 1'b0;
        case (cur)
            IDLE:
                if (stop) entry_nxt = '0;
                else begin
                    if (key_valid && key_digit <= 4'd9 && entry[3:0] <= 4'd5) entry_nxt = {entry[7:0], key_digit};
                    if (start && door_closed && entry != '0) nxt = LOAD;
                end
            LOAD: begin
                pre_nxt = '0;
                nxt = COOK;
            end
            COOK:
                if (halt) nxt = PAUSE;
                else if (timer_zero) nxt = DONE;
                else begin
                    tick = pre == PMAX;
                    pre_nxt = tick ? '0 : pre + 16'd1;
                end
            PAUSE:
                if (stop) begin
                    nxt = IDLE;
                    entry_nxt = '0;
                end else if (start && door_closed) nxt = COOK;
            DONE: nxt = done_exit ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end
    // state, entry, prescaler and registered heater enable
    always_ff @(posedge clk)
        if (clear) begin
            cur <= IDLE;
            entry <= '0;
            pre <= '0;
            mag_on <= 1'b0;
        end else begin
            cur <= nxt;
            entry <= entry_nxt;
            pre <= pre_nxt;
            mag_on <= nxt == COOK;
        end
    assign state = cur;
    assign timer_data = entry;
    assign timer_load = !clear && cur == LOAD;
    assign timer_enable = !clear && tick;
    assign timer_clearn = !(clear || (cur == PAUSE && stop));
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: vector table plus corner sequences, scoreboarded against timer_ctrl
module tb_timer_ctrl;
    localparam logic [2:0] SI = 3'd0, SL = 3'd1, SC = 3'd2, SP = 3'd3, SD = 3'd4;
`ifdef DONE_BEEP_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif
    typedef struct {
        logic clr, kv;
        logic [3:0] kd;
        logic st, sp, dc, tz;
        logic [2:0] es;
        logic [11:0] ed;
        logic el, ee, ec, em, eb;
    } vec_t;
    logic clk = 1'b0, clear, key_valid, start, stop, door_closed, timer_zero;
    logic [3:0] key_digit;
    logic [11:0] timer_data;
    logic timer_load, timer_enable, timer_clearn, mag_on, beep;
    logic [2:0] state;
    int checks = 0, errors = 0;
    vec_t tbl[$];
    vec_t sb[$];
    timer_ctrl #(.TICK_DIV(4), .BEEP_CYCLES(5)) dut (
        .clk(clk), .clear(clear), .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
        .timer_data(timer_data), .timer_load(timer_load), .timer_enable(timer_enable),
        .timer_clearn(timer_clearn), .mag_on(mag_on), .state(state), .beep(beep)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end
    function automatic vec_t v(input logic clr, kv, input logic [3:0] kd, input logic st, sp, dc, tz,
                               input logic [2:0] es, input logic [11:0] ed, input logic el, ee, ec, em);
        vec_t r;
        r.clr = clr; r.kv = kv; r.kd = kd; r.st = st; r.sp = sp; r.dc = dc; r.tz = tz;
        r.es = es; r.ed = ed; r.el = el; r.ee = ee; r.ec = ec; r.em = em;
        r.eb = BEEP && es == SD;
        return r;
    endfunction
    function automatic void chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endfunction
    task automatic apply(input vec_t x);
        vec_t e;
        logic ld, en, cn;
        clear = x.clr; key_valid = x.kv; key_digit = x.kd; start = x.st;
        stop = x.sp; door_closed = x.dc; timer_zero = x.tz;
        sb.push_back(x);
        #2;
        ld = timer_load; en = timer_enable; cn = timer_clearn;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("timer_load", 12'(ld), 12'(e.el));
        chk("timer_enable", 12'(en), 12'(e.ee));
        chk("timer_clearn", 12'(cn), 12'(e.ec));
        chk("state", 12'(state), 12'(e.es));
        chk("timer_data", timer_data, e.ed);
        chk("mag_on", 12'(mag_on), 12'(e.em));
        chk("beep", 12'(beep), 12'(e.eb));
    endtask
    // idle-input step in COOK/PAUSE/DONE with door closed
    function automatic vec_t nop(input logic [2:0] es, input logic [11:0] ed, input logic el, ee, em);
        return v(0, 0, 0, 0, 0, 1, 0, es, ed, el, ee, 1, em);
    endfunction
    initial begin
        clear = 1; key_valid = 0; key_digit = 0; start = 0; stop = 0; door_closed = 1; timer_zero = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, SI, 12'h000, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 0, SI, 12'h001, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 3, 0, 0, 1, 0, SI, 12'h013, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, SI, 12'h130, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 7, 0, 0, 1, 0, SI, 12'h307, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 8, 0, 0, 1, 0, SI, 12'h307, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 4'hA, 0, 0, 1, 0, SI, 12'h307, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, SI, 12'h307, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, SI, 12'h000, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, SI, 12'h000, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 0, SI, 12'h001, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, SI, 12'h010, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 1, 0, SI, 12'h100, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 1, 1, 0, SI, 12'h000, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 2, 0, 0, 1, 0, SI, 12'h002, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, SL, 12'h002, 0, 0, 1, 0));
        tbl.push_back(nop(SC, 12'h002, 1, 0, 1));
        for (int i = 0; i < 8; i++) tbl.push_back(nop(SC, 12'h002, 0, i % 4 == 3, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, SD, 12'h002, 0, 0, 1, 0));
        foreach (tbl[i]) apply(tbl[i]);
`ifdef DONE_BEEP_EN
        for (int i = 0; i < 4; i++) apply(nop(SD, 12'h002, 0, 0, 0));
        apply(nop(SI, 12'h002, 0, 0, 0));
        apply(v(0, 0, 0, 1, 0, 1, 0, SL, 12'h002, 0, 0, 1, 0));
        apply(nop(SC, 12'h002, 1, 0, 1));
        apply(v(0, 0, 0, 0, 0, 1, 1, SD, 12'h002, 0, 0, 1, 0));
        apply(nop(SD, 12'h002, 0, 0, 0));
        apply(v(0, 1, 5, 0, 0, 1, 0, SI, 12'h002, 0, 0, 1, 0));
`else
        apply(nop(SI, 12'h002, 0, 0, 0));
`endif
        apply(v(0, 0, 0, 1, 0, 1, 0, SL, 12'h002, 0, 0, 1, 0));
        apply(nop(SC, 12'h002, 1, 0, 1));
        apply(nop(SC, 12'h002, 0, 0, 1));
        apply(nop(SC, 12'h002, 0, 0, 1));
        apply(v(0, 0, 0, 0, 0, 0, 0, SP, 12'h002, 0, 0, 1, 0));
        apply(nop(SP, 12'h002, 0, 0, 0));
        apply(v(0, 0, 0, 1, 0, 1, 0, SC, 12'h002, 0, 0, 1, 1));
        apply(nop(SC, 12'h002, 0, 0, 1));
        apply(nop(SC, 12'h002, 0, 1, 1));
        for (int i = 0; i < 3; i++) apply(nop(SC, 12'h002, 0, 0, 1));
        apply(v(0, 0, 0, 0, 1, 1, 0, SP, 12'h002, 0, 0, 1, 0));
        apply(v(0, 0, 0, 1, 1, 1, 0, SI, 12'h000, 0, 0, 0, 0));
        apply(nop(SI, 12'h000, 0, 0, 0));
        apply(v(0, 1, 1, 0, 0, 1, 0, SI, 12'h001, 0, 0, 1, 0));
        apply(v(0, 0, 0, 1, 0, 1, 0, SL, 12'h001, 0, 0, 1, 0));
        apply(nop(SC, 12'h001, 1, 0, 1));
        apply(nop(SC, 12'h001, 0, 0, 1));
        apply(v(1, 0, 0, 1, 0, 1, 0, SI, 12'h000, 0, 0, 0, 0));
        apply(nop(SI, 12'h000, 0, 0, 0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
